hc595_rx: RTL

HC595_RX -- requirements
Module: hc595_rx

---
 rtl/hc595_pkg.sv | 41 ++++
 rtl/hc595_sync_edge.sv | 49 ++++
 rtl/hc595_rx.sv | 131 +++++++++++++
 3 files changed

// File: rtl/hc595_pkg.sv
// ---------------------------------------------------------------------------
// hc595_pkg -- definitions shared by the 74HC595 transmit and receive sides.
//
// Frame layout (14 bits, shifted MSB first):
//   frame[13:6] = sec (segment field)
//   frame[5:0]  = sel (digit-select field)
// The helper functions are the single place where the bit order is defined,
// so that both sides pack and unpack the frame the same way.
// ---------------------------------------------------------------------------
package hc595_pkg;

    localparam int SEL_W   = 6;
    localparam int SEC_W   = 8;
    localparam int FRAME_W = 14;

    // Bit positions of each field inside the frame word.
    localparam int SEL_LSB = 0;
    localparam int SEC_LSB = SEL_W;

    // Shift-edge counter: counts up to CNT_MAX and then saturates.
    localparam int             CNT_W      = 4;
    localparam logic [CNT_W-1:0] CNT_MAX    = 4'd15;
    localparam logic [CNT_W-1:0] CNT_FRAME  = 4'd14;

    // Build a frame word from its two fields.
    function automatic logic [FRAME_W-1:0] frame_pack(input logic [SEC_W-1:0] sec,
                                                       input logic [SEL_W-1:0] sel);
        return {sec, sel};
    endfunction

    // Extract the digit-select field from a frame word.
    function automatic logic [SEL_W-1:0] frame_sel(input logic [FRAME_W-1:0] word);
        return word[SEL_LSB +: SEL_W];
    endfunction

    // Extract the segment field from a frame word.
    function automatic logic [SEC_W-1:0] frame_sec(input logic [FRAME_W-1:0] word);
        return word[SEC_LSB +: SEC_W];
    endfunction

endpackage

// File: rtl/hc595_sync_edge.sv
// ---------------------------------------------------------------------------
// hc595_sync_edge -- multi-flop synchronizer with rising-edge detect.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   din    asynchronous input pin
//   dout   synchronized level (STAGES cycles of latency)
//   rise   one-cycle pulse when dout goes 0->1
//
// After reset a fill marker walks through its own STAGES-deep chain, and the
// edge detector is only armed once dout and its history flop both reflect the
// real pin. A pin that is already high when reset releases therefore never
// produces a rise.
// ---------------------------------------------------------------------------
module hc595_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise
);

    logic [STAGES-1:0] sync_r;
    logic [STAGES-1:0] fill_r;
    logic              prev_r;
    logic              armed_r;

    // Synchronizer chain, fill marker and edge history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r  <= {STAGES{1'b0}};
            fill_r  <= {STAGES{1'b0}};
            prev_r  <= 1'b0;
            armed_r <= 1'b0;
        end else begin
            sync_r  <= {sync_r[STAGES-2:0], din};
            fill_r  <= {fill_r[STAGES-2:0], 1'b1};
            prev_r  <= sync_r[STAGES-1];
            armed_r <= fill_r[STAGES-1];
        end
    end

    assign dout = sync_r[STAGES-1];
    assign rise = armed_r & sync_r[STAGES-1] & ~prev_r;

endmodule

// File: rtl/hc595_rx.sv
// ---------------------------------------------------------------------------
// hc595_rx -- receiver that snoops a 74HC595 serial bus (ds/shcp/stcp/oe)
// and recovers the latched {sec, sel} frame.
//
// Parameter:
//   SYNC_STAGES  synchronizer depth on every serial input (>= 2)
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   ds           serial data (async)
//   shcp         shift clock, sampled on its rise (async)
//   stcp         storage clock, frame latched on its rise (async)
//   oe           active-low output enable (async)
//   sel, sec     last latched fields
//   data_valid   one-cycle pulse when sel/sec update
//   frame_err    one-cycle pulse with data_valid when the frame did not have
//                exactly 14 shift edges
//   blank        synchronized oe
//
// Configuration macro HC595_RX_FRAME_CHECK_EN: when defined, a saturating
// shift-edge counter drives frame_err; otherwise frame_err is tied low.
// ---------------------------------------------------------------------------
module hc595_rx
    import hc595_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ds,
    input  logic             shcp,
    input  logic             stcp,
    input  logic             oe,
    output logic [SEL_W-1:0] sel,
    output logic [SEC_W-1:0] sec,
    output logic             data_valid,
    output logic             frame_err,
    output logic             blank
);

    logic                ds_sync_s;
    logic                shcp_rise_s;
    logic                stcp_rise_s;
    logic                shcp_sync_unused_s;
    logic                stcp_sync_unused_s;
    logic                ds_rise_unused_s;
    logic                oe_rise_unused_s;

    logic [FRAME_W-1:0]  shreg_r;
    logic [FRAME_W-1:0]  shreg_next_s;
    logic [SEL_W-1:0]    sel_r;
    logic [SEC_W-1:0]    sec_r;
    logic                data_valid_r;

    // All four inputs share the same depth so ds stays aligned with shcp.
    hc595_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ds (
        .clk(clk), .rst_n(rst_n), .din(ds),   .dout(ds_sync_s),          .rise(ds_rise_unused_s));
    hc595_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_shcp (
        .clk(clk), .rst_n(rst_n), .din(shcp), .dout(shcp_sync_unused_s), .rise(shcp_rise_s));
    hc595_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_stcp (
        .clk(clk), .rst_n(rst_n), .din(stcp), .dout(stcp_sync_unused_s), .rise(stcp_rise_s));
    hc595_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_oe (
        .clk(clk), .rst_n(rst_n), .din(oe),   .dout(blank),              .rise(oe_rise_unused_s));

    // Next shift-register value: shift in the aligned data bit on a shcp rise.
    always_comb begin
        shreg_next_s = shreg_r;
        if (shcp_rise_s) begin
            shreg_next_s = {shreg_r[FRAME_W-2:0], ds_sync_s};
        end else begin
            shreg_next_s = shreg_r;
        end
    end

    // Shift register and output latch; the latch reads the pre-shift value,
    // so a same-cycle shcp+stcp rise stores the old word, like the real part.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_r      <= {FRAME_W{1'b0}};
            sel_r        <= {SEL_W{1'b0}};
            sec_r        <= {SEC_W{1'b0}};
            data_valid_r <= 1'b0;
        end else begin
            shreg_r      <= shreg_next_s;
            data_valid_r <= stcp_rise_s;
            if (stcp_rise_s) begin
                sel_r <= frame_sel(shreg_r);
                sec_r <= frame_sec(shreg_r);
            end
        end
    end

    assign sel        = sel_r;
    assign sec        = sec_r;
    assign data_valid = data_valid_r;

`ifdef HC595_RX_FRAME_CHECK_EN
    logic [CNT_W-1:0] bit_cnt_r;
    logic [CNT_W-1:0] bit_cnt_next_s;
    logic             frame_err_r;

    // Shift-edge counter: restarts on stcp (at 1 if a shift lands in the same
    // cycle), otherwise counts shcp rises and saturates.
    always_comb begin
        bit_cnt_next_s = bit_cnt_r;
        if (stcp_rise_s) begin
            bit_cnt_next_s = shcp_rise_s ? 4'd1 : 4'd0;
        end else if (shcp_rise_s && (bit_cnt_r != CNT_MAX)) begin
            bit_cnt_next_s = bit_cnt_r + 4'd1;
        end else begin
            bit_cnt_next_s = bit_cnt_r;
        end
    end

    // Counter register and error flag, judged on the count before any
    // same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r   <= {CNT_W{1'b0}};
            frame_err_r <= 1'b0;
        end else begin
            bit_cnt_r   <= bit_cnt_next_s;
            frame_err_r <= stcp_rise_s && (bit_cnt_r != CNT_FRAME);
        end
    end

    assign frame_err = frame_err_r;
`else
    assign frame_err = 1'b0;
`endif

endmodule
